// File: rtl/cache_data_array.sv
// N-way set-associative cache data array with per-line dirty bits, byte-masked stores,
// and a write-back / refill sequencer. Tag and LRU decisions arrive as one-hot vectors.
module cache_data_array #(
    parameter int WAY_NUM        = 4,
    parameter int INDEX_WIDTH    = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    localparam int OFS_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
    localparam int STRB_W = WORD_WIDTH / 8,
    localparam int LINE_W = WORDS_PER_LINE * WORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [INDEX_WIDTH-1:0] req_index,
    input  logic [OFS_W-1:0]       req_word,
    input  logic [STRB_W-1:0]      req_wstrb,
    input  logic [WORD_WIDTH-1:0]  req_wdata,
    input  logic [WAY_NUM-1:0]     hit_way,
    input  logic [WAY_NUM-1:0]     victim_way,
    input  logic [ADDR_WIDTH-1:0]  victim_addr,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [ADDR_WIDTH-1:0]  wb_addr,
    output logic [LINE_W-1:0]      wb_data,
    input  logic                   refill_valid,
    input  logic [LINE_W-1:0]      refill_data,
    output logic                   rsp_valid,
    output logic [WORD_WIDTH-1:0]  rsp_data
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
    // high. wb_valid/wb_addr/wb_data hold steady until wb_ready; refill_valid is a
    // single-cycle pulse honoured only while waiting in REFILL.

    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e state;
    state_e state_nxt;

    logic [LINE_W-1:0] data_q  [WAY_NUM][SETS];
    logic [SETS-1:0]   dirty_q [WAY_NUM];

    logic                   wr_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [OFS_W-1:0]       word_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic [WORD_WIDTH-1:0]  wdata_q;
    logic [WAY_W-1:0]       vic_q;

    logic [WAY_W-1:0] hit_sel;
    logic [WAY_W-1:0] vic_sel;
    logic             is_hit;
    logic             accept;
    logic             victim_dirty;
    logic             wb_done;
    logic             refill_done;

    // Lowest set bit wins; an all-zero vector maps to way 0.
    function automatic logic [WAY_W-1:0] lowest_set(input logic [WAY_NUM-1:0] v);
        lowest_set = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = WAY_W'(i);
        end
    endfunction

    function automatic logic [WORD_WIDTH-1:0] get_word(input logic [LINE_W-1:0] line,
                                                       input logic [OFS_W-1:0]  w);
        get_word = line[int'(w)*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0]     line,
                                                     input logic [OFS_W-1:0]      w,
                                                     input logic [STRB_W-1:0]     strb,
                                                     input logic [WORD_WIDTH-1:0] wdata);
        merge_word = line;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) merge_word[int'(w)*WORD_WIDTH + b*8 +: 8] = wdata[b*8 +: 8];
        end
    endfunction

    assign hit_sel      = lowest_set(hit_way);
    assign vic_sel      = lowest_set(victim_way);
    assign is_hit       = |hit_way;
    assign accept       = req_valid && (state == S_IDLE);
    assign victim_dirty = dirty_q[vic_sel][req_index];
    assign wb_done      = (state == S_WB) && wb_ready;
    assign refill_done  = (state == S_REFILL) && refill_valid;
    assign req_ready    = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_hit)            state_nxt = S_RESP;
                    else if (victim_dirty) state_nxt = S_WB;
                    else                   state_nxt = S_REFILL;
                end
            end
            S_WB:     if (wb_ready) state_nxt = S_REFILL;
            S_REFILL: if (refill_valid) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Array and dirty bits: hit stores update at accept, refills land in the victim way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                dirty_q[w] <= '0;
                for (int s = 0; s < SETS; s++) data_q[w][s] <= '0;
            end
        end else if (accept && is_hit && req_wr) begin
            data_q[hit_sel][req_index]  <= merge_word(data_q[hit_sel][req_index], req_word,
                                                      req_wstrb, req_wdata);
            dirty_q[hit_sel][req_index] <= 1'b1;
        end else if (wb_done) begin
            dirty_q[vic_q][index_q] <= 1'b0;
        end else if (refill_done) begin
            data_q[vic_q][index_q]  <= wr_q ? merge_word(refill_data, word_q, wstrb_q, wdata_q)
                                            : refill_data;
            dirty_q[vic_q][index_q] <= wr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            index_q   <= '0;
            word_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            vic_q     <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr;
                index_q <= req_index;
                word_q  <= req_word;
                wstrb_q <= req_wstrb;
                wdata_q <= req_wdata;
                vic_q   <= vic_sel;
                if (is_hit) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= req_wr ? '0 : get_word(data_q[hit_sel][req_index], req_word);
                end else if (victim_dirty) begin
                    wb_valid <= 1'b1;
                    wb_addr  <= victim_addr;
                    wb_data  <= data_q[vic_sel][req_index];
                end
            end
            if (wb_done) wb_valid <= 1'b0;
            if (refill_done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= wr_q ? '0 : get_word(refill_data, word_q);
            end
            if (state == S_RESP) begin
                rsp_valid <= 1'b0;
                rsp_data  <= '0;
            end
        end
    end

endmodule
